lane_scheduler: RTL and testbench
=================================

LANE_SCHEDULER -- requirements
Module: lane_scheduler

Interface
REQ-001 Parameter BASE_ROW, default 1: frog row of lane 0; lane k occupies row BASE_ROW+k.
REQ-002 Parameter GOAL_ROW, default 15: frog row that counts as a level win.
REQ-003 Parameter LANE_PERIOD, default {4,3,2,1}: base tick period per lane (lane 0 first); each value 1..7.
REQ-004 clk  in  1  single system clock; all logic on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  level; leaves IDLE when high.
REQ-007 tick  in  1  one-cycle base time pulse from an external prescaler.
REQ-008 frog_row  in  4  frog row, 0..15.
REQ-009 frog_col  in  4  frog column, 0..15; indexes lane pixel bit frog_col.
REQ-010 lane_pixels  in  64  lane k pattern on bits [16k+15:16k].
REQ-011 advance  out  4  bit k: one-cycle pulse stepping lane k's pattern.
REQ-012 hit  out  4  bit k: one-cycle pulse telling lane k a collision occurred.
REQ-013 win  out  1  one-cycle pulse on level completion.
REQ-014 level  out  2  current level, 0..3.
REQ-015 game_over  out  1  high while in OVER.

Function
REQ-016 FSM states: IDLE, RUN, HIT, OVER.
REQ-017 IDLE->RUN when start=1. Otherwise IDLE holds, with lane counters cleared and all pulses 0.
REQ-018 Collision in RUN: frog_row in BASE_ROW..BASE_ROW+3 (lane k = frog_row-BASE_ROW) and lane_pixels[16k+frog_col]=1.
REQ-019 On a collision in RUN, the next state is HIT.
  - hit[k]=1 for exactly the one cycle spent in HIT; all other hit bits stay 0.
REQ-020 HIT->OVER unconditionally. OVER holds until reset, with game_over=1, advance=0, hit=0, win=0.
REQ-021 Win in RUN: frog_row==GOAL_ROW with no collision.
  - win=1 on the next cycle.
  - level increments, saturating at 3.
  - all lane counters clear.
  - state stays RUN.
REQ-022 Effective period per lane: P_k = max(1, LANE_PERIOD[k] - level), computed unsigned in 3 bits.
REQ-023 Each lane has a 3-bit counter cnt_k, updated in RUN only.
  - On tick with cnt_k==P_k-1: cnt_k<=0 and advance[k]=1 on the next cycle.
  - On tick otherwise: cnt_k increments.
REQ-024 All outputs are registered. advance, hit and win each rise exactly one cycle after the sampled cause.
REQ-025 Precedence in one cycle: collision > win > advance.
  - On collision, no advance or win pulse is issued and counters freeze.
REQ-026 If level drops P_k below cnt_k+1, the counter still wraps: the next tick with cnt_k>=P_k-1 fires advance[k] and clears cnt_k.
REQ-027 A tick arriving in IDLE, HIT or OVER is ignored. Counters hold in HIT and OVER.

Reset
REQ-028 When reset=1 at a clock edge, the next state is IDLE from any state, including mid-HIT.
  - Outputs after that edge: level=0, all counters 0, advance=0, hit=0, win=0, game_over=0.
REQ-029 No output depends on an uninitialised register after the first reset edge.

Structure
REQ-030 Shared package frogger_pkg holds:
  - the state enum {IDLE, RUN, HIT, OVER};
  - NUM_LANES=4 and LANE_W=16;
  - the default LANE_PERIOD constant.
REQ-031 Sub-module lane_timer (one per lane, instantiated NUM_LANES times) holds:
  - inputs: clk, reset, clear, enable, tick, period[2:0];
  - output: step pulse;
  - the counter logic of REQ-023/026.
REQ-032 lane_scheduler keeps the FSM, collision mux, level register and output registers.

Verification
REQ-033 reset, start=1, tick every 4 cycles, frog_row=0, level 0 -> advance[3] every tick, advance[0] every 4th tick; each pulse is one cycle wide, one cycle after its tick.
REQ-034 RUN, frog_row=2, frog_col=5, lane_pixels[21]=1 -> hit=4'b0010 for one cycle, then game_over=1; advance stays 0 under further ticks.
REQ-035 Collision and a tick that would fire advance[1] in the same cycle -> hit[1] pulses, no advance pulse.
REQ-036 Four wins (frog_row=15 in RUN) -> win pulses 4 times; level reads 1,2,3,3; at level 3 lane 0 period is 1, so advance[0] fires every tick.
REQ-037 reset asserted during HIT -> next cycle IDLE, hit=0, game_over=0, level=0; ticks are ignored until start.

Source files
------------

// File: rtl/frogger_pkg.sv
// frogger_pkg: shared state encoding, lane geometry and default lane periods
package frogger_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HIT, OVER} state_t;
  localparam int NUM_LANES = 4;
  localparam int LANE_W = 16;
  localparam logic [NUM_LANES-1:0][2:0] DEF_LANE_PERIOD = {3'd1, 3'd2, 3'd3, 3'd4};
endpackage

// File: rtl/lane_scheduler_if.sv
// lane_scheduler_if: game inputs and lane control outputs of the scheduler
interface lane_scheduler_if;
  import frogger_pkg::*;
  logic start;
  logic tick;
  logic [3:0] frog_row;
  logic [3:0] frog_col;
  logic [NUM_LANES*LANE_W-1:0] lane_pixels;
  logic [NUM_LANES-1:0] advance;
  logic [NUM_LANES-1:0] hit;
  logic win;
  logic [1:0] level;
  logic game_over;
  modport master (
    output start, tick, frog_row, frog_col, lane_pixels,
    input advance, hit, win, level, game_over
  );
  modport slave (
    input start, tick, frog_row, frog_col, lane_pixels,
    output advance, hit, win, level, game_over
  );
endinterface

// File: rtl/lane_timer.sv
// lane_timer: per-lane tick divider producing a one-cycle step pulse
module lane_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       tick,
  input  logic [2:0] period,
  output logic       step
);
  logic [2:0] cnt;
  logic wrap;
  // >= rather than == so a counter left above a shrunken period still wraps
  assign wrap = cnt >= period - 3'd1;
  // count enabled ticks, fire step and restart on wrap
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt  <= '0;
      step <= 1'b0;
    end else begin
      step <= enable && tick && wrap;
      if (enable && tick) cnt <= wrap ? 3'd0 : cnt + 3'd1;
    end
  end
endmodule

// File: rtl/lane_scheduler.sv
// lane_scheduler: game FSM, collision detection, level tracking and lane timing
module lane_scheduler
  import frogger_pkg::*;
#(
  parameter int BASE_ROW = 1,
  parameter int GOAL_ROW = 15,
  parameter logic [NUM_LANES-1:0][2:0] LANE_PERIOD = DEF_LANE_PERIOD
) (
  input logic clk,
  input logic reset,
  lane_scheduler_if.slave bus
);
  state_t state;
  logic [1:0] level;
  logic [NUM_LANES-1:0] hit;
  logic [NUM_LANES-1:0] adv;
  logic win;
  logic game_over;
  logic [3:0] rel;
  logic in_lane;
  logic coll;
  logic win_c;
  logic run_en;
  logic clr;
  assign rel     = bus.frog_row - 4'(BASE_ROW);
  assign in_lane = bus.frog_row >= 4'(BASE_ROW) && rel < 4'(NUM_LANES);
  assign coll    = state == RUN && in_lane && bus.lane_pixels[{rel[1:0], bus.frog_col}];
  assign win_c   = state == RUN && !coll && bus.frog_row == 4'(GOAL_ROW);
  assign run_en  = state == RUN && !coll;
  assign clr     = state == IDLE || win_c;
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [2:0] period;
    // period shrinks with level but never below one tick
    assign period = LANE_PERIOD[k] > {1'b0, level} ? LANE_PERIOD[k] - {1'b0, level} : 3'd1;
    lane_timer u_timer (
      .clk(clk),
      .reset(reset),
      .clear(clr),
      .enable(run_en),
      .tick(bus.tick),
      .period(period),
      .step(adv[k])
    );
  end
  // game FSM with registered hit/win/game_over pulses and level counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      level     <= 2'd0;
      hit       <= '0;
      win       <= 1'b0;
      game_over <= 1'b0;
    end else begin
      hit <= '0;
      win <= 1'b0;
      case (state)
        IDLE: if (bus.start) state <= RUN;
        RUN: begin
          if (coll) begin
            state <= HIT;
            hit   <= 4'(1) << rel[1:0];
          end else if (win_c) begin
            win   <= 1'b1;
            level <= level == 2'd3 ? 2'd3 : level + 2'd1;
          end
        end
        HIT: begin
          state     <= OVER;
          game_over <= 1'b1;
        end
        default: game_over <= 1'b1;
      endcase
    end
  end
  assign bus.advance   = adv;
  assign bus.hit       = hit;
  assign bus.win       = win;
  assign bus.level     = level;
  assign bus.game_over = game_over;
endmodule

// File: tb/tb_lane_scheduler.sv
// tb_lane_scheduler: directed and random checks against a behavioural game model
module tb_lane_scheduler;
  localparam int BASE = 1;
  localparam int GOAL = 15;
  localparam int LP[4] = '{4, 3, 2, 1};
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  int ms, ml;
  int mc[4];
  logic [3:0] ea, eh;
  logic ew, eg;
  int n_adv0, n_adv3;
  lane_scheduler_if bus ();
  lane_scheduler dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(input logic r, input logic s, input logic t, input logic [3:0] row,
                     input logic [3:0] col, input logic [63:0] pix);
    int lane, p;
    reset = r;
    bus.start = s;
    bus.tick = t;
    bus.frog_row = row;
    bus.frog_col = col;
    bus.lane_pixels = pix;
    ea = '0;
    eh = '0;
    ew = 1'b0;
    lane = int'(row) - BASE;
    if (r) begin
      ms = 0;
      ml = 0;
      mc = '{default: 0};
    end else if (ms == 0) begin
      mc = '{default: 0};
      if (s) ms = 1;
    end else if (ms == 1) begin
      if (lane >= 0 && lane < 4 && pix[lane*16+int'(col)]) begin
        ms = 2;
        eh[lane] = 1'b1;
      end else if (int'(row) == GOAL) begin
        ew = 1'b1;
        ml = ml < 3 ? ml + 1 : 3;
        mc = '{default: 0};
      end else if (t) begin
        for (int k = 0; k < 4; k++) begin
          p = LP[k] - ml < 1 ? 1 : LP[k] - ml;
          if (mc[k] >= p - 1) begin
            mc[k] = 0;
            ea[k] = 1'b1;
          end else mc[k]++;
        end
      end
    end else if (ms == 2) ms = 3;
    eg = ms == 3;
    @(posedge clk);
    #1;
    check("advance", bus.advance, ea);
    check("hit", bus.hit, eh);
    check("win", {3'b0, bus.win}, {3'b0, ew});
    check("level", {2'b0, bus.level}, 4'(ml));
    check("game_over", {3'b0, bus.game_over}, {3'b0, eg});
    if (bus.advance[0]) n_adv0++;
    if (bus.advance[3]) n_adv3++;
  endtask
  initial begin
    logic [3:0] lv_exp[4];
    logic [63:0] pix21;
    lv_exp = '{4'd1, 4'd2, 4'd3, 4'd3};
    pix21 = 64'd1 << 21;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    n_adv0 = 0;
    n_adv3 = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 1, 0, 0, 0);
      for (int j = 0; j < 3; j++) cyc(0, 1, 0, 0, 0, 0);
    end
    check("adv3_count", 4'(n_adv3), 4'd15 + 4'd1 == 4'd0 ? 4'd0 : 4'(16));
    check("adv0_count", 4'(n_adv0), 4'd4);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 2, 5, pix21);
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0, 0);
    check("over_flag", {3'b0, bus.game_over}, 4'd1);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 2, 5, pix21);
    check("hit_lane1", bus.hit, 4'b0010);
    cyc(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 15, 0, 0);
      check("level_seq", {2'b0, bus.level}, lv_exp[i]);
    end
    n_adv0 = 0;
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0, 0);
    check("adv0_lvl3", 4'(n_adv0), 4'd4);
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] row;
      logic [63:0] pix;
      row = $urandom_range(0, 7) == 0 ? 4'($urandom_range(1, 4)) :
            $urandom_range(0, 15) == 0 ? 4'd15 : 4'($urandom_range(5, 14));
      pix = {$urandom, $urandom} & {$urandom, $urandom};
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          row, 4'($urandom_range(0, 15)), pix);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
